// File: rtl/memory_arbiter_pkg.sv
// =============================================================================
// Module : memory_arbiter_pkg
// Purpose: Shared types and constants for the three-port memory arbiter:
//          FSM state encoding, requester identifiers and the data word
//          returned to a requester whose access was aborted by the timeout.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package memory_arbiter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } e_state;

  typedef enum logic [1:0] {
    R_BUS = 2'd0,
    R_DMA = 2'd1,
    R_AUX = 2'd2
  } e_requester;

  // Read data presented to the requester when an access is aborted.
  localparam logic [15:0] ABORT_RDATA = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter_grant.sv
// =============================================================================
// Module : memory_arbiter_grant
// Purpose: Purely combinational grant selection. The bus has priority, unless
//          it has already starved the DMA/aux side for the configured number
//          of grants. DMA and aux share the low-priority slot round-robin.
// Ports  : bus_request/dma_request/aux_request - live request levels
//          rr_aux      - 1 when aux wins a DMA/aux tie, 0 when DMA wins
//          starved     - starvation counter has reached its limit
//          grant_valid - at least one requester is asking
//          grant_sel   - chosen requester (e_requester encoding)
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module memory_arbiter_grant
  import memory_arbiter_pkg::*;
(
  input  logic       bus_request,
  input  logic       dma_request,
  input  logic       aux_request,
  input  logic       rr_aux,
  input  logic       starved,
  output logic       grant_valid,
  output logic [1:0] grant_sel
);

  logic       side_pending;
  logic [1:0] side_sel;

  always_comb begin
    side_pending = dma_request | aux_request;
    // A lone DMA/aux requester wins outright; the pointer only breaks ties.
    side_sel     = (dma_request && (!aux_request || !rr_aux)) ? R_DMA : R_AUX;
    grant_valid  = bus_request | side_pending;

    if (bus_request && !(starved && side_pending)) begin
      grant_sel = R_BUS;
    end else if (side_pending) begin
      grant_sel = side_sel;
    end else begin
      grant_sel = R_BUS;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// =============================================================================
// Module : memory_arbiter
// Purpose: Arbitrates bus, DMA and aux requesters onto a single 26-bit
//          address / 16-bit data memory port. One access is outstanding at a
//          time; the granted requester's ack is a combinational copy of
//          mem_ack during the wait state.
// Ports  : clk, reset_n (async, active-low)
//          X_request/X_write/X_address/X_wdata (X = bus, dma, aux) - requests
//          X_ack/X_rdata - per-requester completion and read data
//          mem_request/mem_write/mem_address/mem_wdata/mem_ack/mem_rdata
//          busy - access outstanding; grant_id - last grant (0 bus,1 dma,2 aux)
//          timeout_error (sticky) / error_clear
// Build  : define MEMORY_ARBITER_TIMEOUT_EN to abort accesses that wait
//          TIMEOUT_CYCLES cycles without mem_ack.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_request,
  input  logic        bus_write,
  input  logic [31:0] bus_address,
  input  logic [15:0] bus_wdata,
  output logic        bus_ack,
  output logic [15:0] bus_rdata,
  input  logic        dma_request,
  input  logic        dma_write,
  input  logic [31:0] dma_address,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  input  logic        aux_request,
  input  logic        aux_write,
  input  logic [31:0] aux_address,
  input  logic [15:0] aux_wdata,
  output logic        aux_ack,
  output logic [15:0] aux_rdata,
  output logic        mem_request,
  output logic        mem_write,
  output logic [25:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_error,
  input  logic        error_clear
);

  localparam int unsigned SC_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

  e_state          state, state_next;
  logic [SC_W-1:0] starve_cnt;
  logic            rr_aux;
  logic            grant_valid;
  logic [1:0]      grant_sel;
  logic            grant_take;
  logic            done_ack;
  logic            timeout_hit;
  logic            finish;
  logic            starved;
  logic            sel_write;
  logic [25:0]     sel_address;
  logic [15:0]     sel_wdata;
  logic [15:0]     rdata;
  logic            unused_ok;

  assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));

  memory_arbiter_grant u_grant (
    .bus_request (bus_request),
    .dma_request (dma_request),
    .aux_request (aux_request),
    .rr_aux      (rr_aux),
    .starved     (starved),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt;

  // wait_cnt counts completed WAIT cycles, so the abort fires in the
  // TIMEOUT_CYCLES-th cycle after the grant edge. A real ack in that same
  // cycle takes precedence.
  assign timeout_hit = (state == S_WAIT) && !mem_ack &&
                       (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      if (grant_take) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_error <= 1'b1;
      end else if (error_clear) begin
        timeout_error <= 1'b0;
      end
    end
  end

  assign unused_ok = ^{bus_address[31:26], dma_address[31:26], aux_address[31:26]};
`else
  assign timeout_hit   = 1'b0;
  assign timeout_error = 1'b0;
  assign unused_ok     = ^{error_clear, bus_address[31:26], dma_address[31:26],
                           aux_address[31:26], (TIMEOUT_CYCLES != 0)};
`endif

  // Fields of whichever requester the grant logic is selecting this cycle.
  always_comb begin
    sel_write   = bus_write;
    sel_address = bus_address[25:0];
    sel_wdata   = bus_wdata;
    case (grant_sel)
      R_DMA: begin
        sel_write   = dma_write;
        sel_address = dma_address[25:0];
        sel_wdata   = dma_wdata;
      end
      R_AUX: begin
        sel_write   = aux_write;
        sel_address = aux_address[25:0];
        sel_wdata   = aux_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_take = 1'b0;
    done_ack   = 1'b0;
    finish     = 1'b0;
    bus_ack    = 1'b0;
    dma_ack    = 1'b0;
    aux_ack    = 1'b0;
    case (state)
      S_IDLE: begin
        // mem_ack is deliberately not looked at here.
        if (grant_valid) begin
          grant_take = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        done_ack = mem_ack;
        finish   = done_ack | timeout_hit;
        if (finish) begin
          state_next = S_IDLE;
          bus_ack    = (grant_id == R_BUS);
          dma_ack    = (grant_id == R_DMA);
          aux_ack    = (grant_id == R_AUX);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      grant_id    <= R_BUS;
      starve_cnt  <= '0;
      rr_aux      <= 1'b0;
    end else if (grant_take) begin
      mem_request <= 1'b1;
      mem_write   <= sel_write;
      mem_address <= sel_address;
      mem_wdata   <= sel_wdata;
      grant_id    <= grant_sel;
      if (grant_sel == R_BUS) begin
        // Only bus grants that overtake a waiting DMA/aux request count.
        if ((dma_request || aux_request) && !starved) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
        rr_aux     <= ~rr_aux;
      end
    end else if (finish) begin
      mem_request <= 1'b0;
    end
  end

  assign rdata     = timeout_hit ? ABORT_RDATA : mem_rdata;
  assign bus_rdata = rdata;
  assign dma_rdata = rdata;
  assign aux_rdata = rdata;
  assign busy      = (state == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// =============================================================================
// Module : tb_memory_arbiter
// Purpose: Self-checking bench for memory_arbiter. A driver issues requests
//          and pushes predicted grants/acks into queues; a monitor on the
//          falling clock edge pops and compares whenever the DUT starts an
//          access or raises an ack.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int unsigned STARVE_LIMIT   = 4;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_request = 0, bus_write = 0, dma_request = 0, dma_write = 0;
  logic        aux_request = 0, aux_write = 0;
  logic [31:0] bus_address = 0, dma_address = 0, aux_address = 0;
  logic [15:0] bus_wdata = 0, dma_wdata = 0, aux_wdata = 0;
  logic        bus_ack, dma_ack, aux_ack;
  logic [15:0] bus_rdata, dma_rdata, aux_rdata;
  logic        mem_request, mem_write, mem_ack = 0;
  logic [25:0] mem_address;
  logic [15:0] mem_wdata, mem_rdata = 0;
  logic        busy, timeout_error, error_clear = 0;
  logic [1:0]  grant_id;

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dma_request(dma_request), .dma_write(dma_write), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .aux_request(aux_request), .aux_write(aux_write), .aux_address(aux_address),
    .aux_wdata(aux_wdata), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .timeout_error(timeout_error),
    .error_clear(error_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard queues ----------------
  typedef struct { int id; bit wr; logic [25:0] addr; logic [15:0] wd; } grant_t;
  typedef struct { int id; logic [15:0] rd; } ack_t;

  grant_t grant_q[$];
  ack_t   ack_q[$];
  int     grant_log[$];
  int     starve   = 0;   // bus grants that overtook a waiting DMA/aux request
  bit     turn_aux = 0;   // DMA/aux tie goes to aux when set
  bit     exp_busy = 0;

  // Who wins given the request levels, then advance the model's history.
  function automatic int predict(input bit b, input bit d, input bit a);
    int  w;
    bit  side;
    side = d | a;
    if (b && !(side && starve >= int'(STARVE_LIMIT))) w = 0;
    else if (side) w = (d && a) ? (turn_aux ? 2 : 1) : (d ? 1 : 2);
    else w = -1;
    if (w == 0) begin
      if (side && starve < int'(STARVE_LIMIT)) starve++;
    end else if (w > 0) begin
      starve   = 0;
      turn_aux = !turn_aux;
    end
    return w;
  endfunction

  task automatic push_grant(input int w);
    grant_t g;
    g.id = w;
    case (w)
      0:       begin g.wr = bus_write; g.addr = bus_address[25:0]; g.wd = bus_wdata; end
      1:       begin g.wr = dma_write; g.addr = dma_address[25:0]; g.wd = dma_wdata; end
      default: begin g.wr = aux_write; g.addr = aux_address[25:0]; g.wd = aux_wdata; end
    endcase
    grant_q.push_back(g);
  endtask

  task automatic rand_fields();
    bus_write = 1'($urandom); bus_address = $urandom; bus_wdata = 16'($urandom);
    dma_write = 1'($urandom); dma_address = $urandom; dma_wdata = 16'($urandom);
    aux_write = 1'($urandom); aux_address = $urandom; aux_wdata = 16'($urandom);
  endtask

  function automatic logic [15:0] rdata_of(input int id);
    case (id)
      0:       return bus_rdata;
      1:       return dma_rdata;
      default: return aux_rdata;
    endcase
  endfunction

  // ---------------- monitor ----------------
  grant_t cur;
  logic   prev_req = 1'b0;

  always @(negedge clk) begin : mon
    logic [2:0] acks;
    ack_t       k;
    acks = {aux_ack, dma_ack, bus_ack};
    if (reset_n) begin
      chk("busy", busy, exp_busy);
      if (mem_request && !prev_req) begin
        if (grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got grant_id %0d expected none", grant_id);
        end else begin
          cur = grant_q.pop_front();
          grant_log.push_back(int'(grant_id));
          chk("grant_id", grant_id, cur.id);
          chk("mem_write", mem_write, cur.wr);
          chk("mem_address", mem_address, cur.addr);
          chk("mem_wdata", mem_wdata, cur.wd);
        end
      end else if (mem_request) begin
        chk("hold_address", mem_address, cur.addr);
        chk("hold_wdata", mem_wdata, cur.wd);
        chk("hold_write", mem_write, cur.wr);
      end
      if (acks != 3'b000) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_ack: got acks %b expected 000", acks);
        end else begin
          k = ack_q.pop_front();
          chk("ack_vector", acks, 32'(3'b001 << k.id));
          chk("ack_rdata", rdata_of(k.id), k.rd);
        end
      end
    end
    prev_req = mem_request;
  end

  // ---------------- driver ----------------
  // Entered just after a rising edge with the DUT idle; returns likewise.
  task automatic txn(input bit b, input bit d, input bit a, input int lat, input bit idle_ack);
    int          w;
    ack_t        k;
    logic [15:0] rd;
    bus_request = b; dma_request = d; aux_request = a;
    w = predict(b, d, a);
    if (w < 0) begin
      mem_ack   = idle_ack;
      mem_rdata = 16'($urandom);
      #1 chk("idle_no_ack", {aux_ack, dma_ack, bus_ack}, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle_busy", busy, 0);
      return;
    end
    push_grant(w);
    @(posedge clk); #1;
    exp_busy = 1'b1;
    for (int i = 1; i < lat; i++) begin
      rand_fields();
      bus_request = 1'($urandom); dma_request = 1'($urandom); aux_request = 1'($urandom);
      @(posedge clk); #1;
    end
    rd = 16'($urandom);
    mem_rdata = rd; mem_ack = 1'b1;
    k.id = w; k.rd = rd;
    ack_q.push_back(k);
    @(posedge clk); #1;
    mem_ack = 1'b0; exp_busy = 1'b0;
    bus_request = 0; dma_request = 0; aux_request = 0;
    rand_fields();
  endtask

  int seq_exp[14] = '{0, 1, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    int base;
    #3;
    chk("rst_mem_request", mem_request, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {aux_ack, dma_ack, bus_ack}, 0);
    chk("rst_timeout_error", timeout_error, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests, then bus returning after its idle cycle.
    base = grant_log.size();
    txn(1, 1, 1, 2, 0);
    txn(0, 1, 1, 2, 0);
    txn(1, 0, 1, 2, 0);
    txn(0, 0, 1, 2, 0);
    // Bus hogging with DMA pending, twice, to see the starvation count restart.
    for (int i = 0; i < 10; i++) txn(1, 1, 0, 1 + (i % 3), 0);
    chk("seq_len", grant_log.size() - base, 14);
    for (int i = 0; i < 14; i++)
      if (base + i < grant_log.size()) chk("grant_sequence", grant_log[base + i], seq_exp[i]);

    // High address bits are dropped; write fields held through the access.
    bus_write = 1'b1; bus_address = 32'hFC00_1234; bus_wdata = 16'hBEEF;
    txn(1, 0, 0, 4, 0);
    chk("trunc_address", grant_log.size() > 0 ? 32'(cur.addr) : 32'hDEAD, 32'h0001234);

    // mem_ack while idle must be ignored.
    txn(0, 0, 0, 1, 1);
    txn(0, 0, 0, 1, 1);

    // Reset in the middle of an access: immediate abort, no ack.
    rand_fields();
    dma_request = 1'b1;
    w = predict(0, 1, 0);
    push_grant(w);
    @(posedge clk); #1;
    exp_busy = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0; exp_busy = 1'b0; starve = 0; turn_aux = 0;
    #1;
    chk("abort_mem_request", mem_request, 0);
    chk("abort_busy", busy, 0);
    chk("abort_acks", {aux_ack, dma_ack, bus_ack}, 0);
    chk("abort_grant_id", grant_id, 0);
    dma_request = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1, 0, 2, 0);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    begin : timeout_case
      ack_t k;
      rand_fields();
      dma_request = 1'b1;
      w = predict(0, 1, 0);
      push_grant(w);
      k.id = 1; k.rd = 16'hFFFF;
      ack_q.push_back(k);
      @(posedge clk); #1;
      exp_busy = 1'b1; dma_request = 1'b0;
      repeat (TIMEOUT_CYCLES) @(posedge clk);
      #1;
      exp_busy = 1'b0;
      chk("timeout_error_set", timeout_error, 1);
      error_clear = 1'b1;
      @(posedge clk); #1;
      error_clear = 1'b0;
      chk("timeout_error_clear", timeout_error, 0);
    end
`else
    error_clear = 1'b1;
    @(posedge clk); #1;
    error_clear = 1'b0;
    chk("timeout_error_const", timeout_error, 0);
    // Without the timeout a long wait simply continues.
    txn(0, 0, 1, 40, 0);
`endif

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      rand_fields();
      txn(1'(($urandom % 3) != 0), 1'($urandom), 1'($urandom),
          int'($urandom_range(1, 4)), 1'($urandom));
    end

    @(posedge clk); #1;
    chk("grant_queue_drained", grant_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
